// File: rtl/jump_target_gen_if.sv
// jump_target_gen_if
//  Request/result bundle for the jump target generator.
//  master: control unit side (drives start/mode/imm/pc, observes results).
//  slave:  generator side.
//  Signals:
//   start  request strobe
//   mode   00 SEXT, 01 ZEXT, 10 REGION, 11 PCREL
//   imm    instruction immediate (IMM_W)
//   pc     current PC (ADDR_W)
//   busy   request in flight
//   done   one-cycle result strobe
//   target result (ADDR_W)
//   wrap   PCREL out-of-range flag
interface jump_target_gen_if #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 26
);
  logic              start;
  logic [1:0]        mode;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] target;
  logic              wrap;

  modport master (
    output start, mode, imm, pc,
    input  busy, done, target, wrap
  );

  modport slave (
    input  start, mode, imm, pc,
    output busy, done, target, wrap
  );
endinterface

// File: rtl/jump_target_gen.sv
// jump_target_gen
//  Multicycle jump/branch target generator. A request is latched in IDLE,
//  the immediate is extended in EXTEND, the mode result is formed in
//  COMBINE and announced with a one-cycle done pulse in DONE.
//  Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  jump_target_gen_if.slave (start/mode/imm/pc in; busy/done/target/wrap out)
module jump_target_gen #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 26,
  parameter int SHIFT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  jump_target_gen_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXTEND  = 2'd1;
  localparam logic [1:0] S_COMBINE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] M_SEXT   = 2'b00;
  localparam logic [1:0] M_ZEXT   = 2'b01;
  localparam logic [1:0] M_REGION = 2'b10;
  localparam logic [1:0] M_PCREL  = 2'b11;

  // Low bits owned by the shifted immediate in REGION mode; computed one bit
  // wider so IMM_W+SHIFT == ADDR_W yields an all-ones mask (no PC bits kept).
  localparam logic [ADDR_W:0] LO_MASK_W =
    ({{ADDR_W{1'b0}}, 1'b1} << (IMM_W + SHIFT)) - 1'b1;
  localparam logic [ADDR_W-1:0] HI_MASK = ~LO_MASK_W[ADDR_W-1:0];

  logic [1:0]        state;
  logic [1:0]        mode_q;
  logic [IMM_W-1:0]  imm_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] ext;
  logic [ADDR_W-1:0] target_q;
  logic              wrap_q;

  // COMBINE-stage datapath
  logic              fill;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W:0]   sum;
  logic              off_neg;
  logic [ADDR_W-1:0] region;
  logic [ADDR_W-1:0] res;
  logic              res_wrap;

  always_comb begin
    fill = ((mode_q == M_SEXT) || (mode_q == M_PCREL)) ? imm_q[IMM_W-1] : 1'b0;
  end

  always_comb begin
    off      = ext << SHIFT;
    sum      = {1'b0, pc_q} + {1'b0, off};
    // Offset sign comes from the immediate MSB; IMM_W+SHIFT <= ADDR_W keeps it
    // intact through the shift.
    off_neg  = imm_q[IMM_W-1];
    region   = (pc_q & HI_MASK) | (ADDR_W'(imm_q) << SHIFT);
    res      = ext;
    res_wrap = 1'b0;
    case (mode_q)
      M_SEXT,
      M_ZEXT:   res = ext;
      M_REGION: res = region;
      M_PCREL: begin
        res = sum[ADDR_W-1:0];
        // Unsigned PC plus signed offset leaves range when a positive offset
        // carries out, or a negative one fails to borrow back (no carry).
        res_wrap = off_neg ? ~sum[ADDR_W] : sum[ADDR_W];
      end
      default: res = ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      ext      <= '0;
      target_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            imm_q  <= bus.imm;
            pc_q   <= bus.pc;
            state  <= S_EXTEND;
          end
        end
        S_EXTEND: begin
          ext   <= {{(ADDR_W-IMM_W){fill}}, imm_q};
          state <= S_COMBINE;
        end
        S_COMBINE: begin
          target_q <= res;
          wrap_q   <= res_wrap;
          state    <= S_DONE;
        end
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_EXTEND) || (state == S_COMBINE);
  assign bus.done  = (state == S_DONE);
  assign bus.target = target_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_jump_target_gen.sv
// tb_jump_target_gen
//  Directed vectors for jump_target_gen at ADDR_W=32, IMM_W=26, SHIFT=2.
//  Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_jump_target_gen;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  jump_target_gen_if #(.ADDR_W(32), .IMM_W(26)) bus ();

  jump_target_gen #(.ADDR_W(32), .IMM_W(26), .SHIFT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request. lat counts rising edges from the sampling edge to done.
  // Inputs are scrambled after sampling; poke re-pulses start while busy.
  task automatic do_op(input logic [1:0] m, input logic [25:0] im, input logic [31:0] p,
                       input bit poke, output logic [31:0] tgt, output logic wr,
                       output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.imm = im; bus.pc = p;
    @(negedge clk);
    bus.start = poke; bus.mode = ~m; bus.imm = ~im; bus.pc = ~p;
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    tgt = bus.target;
    wr  = bus.wrap;
  endtask

  task automatic op_chk(input string tag, input logic [1:0] m, input logic [25:0] im,
                        input logic [31:0] p, input logic [31:0] et, input logic ew);
    logic [31:0] t;
    logic        w;
    int          l;
    do_op(m, im, p, 1'b0, t, w, l);
    chk({tag, "_lat"}, l, 3);
    chk({tag, "_tgt"}, t, et);
    chk({tag, "_wrap"}, {31'b0, w}, {31'b0, ew});
  endtask

  initial begin
    logic [31:0] t;
    logic        w;
    int          l;
    int          ndone;
    int          first;
    int          gap;
    int          last;

    total = 0; bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0; bus.imm = '0; bus.pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_tgt", bus.target, 32'd0);
    chk("rst_wrap", {31'b0, bus.wrap}, 32'd0);
    rst = 1'b0;

    // busy in the two cycles after sampling, never together with done
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd0; bus.imm = 26'h0000123; bus.pc = 32'h0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("lat_busy1", {30'b0, bus.busy, bus.done}, 32'd2);
    @(negedge clk);
    chk("lat_busy2", {30'b0, bus.busy, bus.done}, 32'd2);
    @(negedge clk);
    chk("lat_done", {30'b0, bus.busy, bus.done}, 32'd1);
    chk("sext_pos", bus.target, 32'h00000123);
    @(negedge clk);
    chk("done_pulse", {30'b0, bus.busy, bus.done}, 32'd0);
    chk("hold_idle", bus.target, 32'h00000123);

    op_chk("sext_neg",  2'd0, 26'h2000000, 32'h12345678, 32'hFE000000, 1'b0);
    op_chk("zext",      2'd1, 26'h3FFFFFF, 32'h12345678, 32'h03FFFFFF, 1'b0);
    op_chk("region",    2'd2, 26'h0000010, 32'hA0001234, 32'hA0000040, 1'b0);
    op_chk("pcrel_b",   2'd3, 26'h3FFFFFF, 32'h00001000, 32'h00000FFC, 1'b0);
    op_chk("pcrel_uf",  2'd3, 26'h3FFFFFF, 32'h00000000, 32'hFFFFFFFC, 1'b1);
    op_chk("pcrel_of",  2'd3, 26'h0000008, 32'hFFFFFFF0, 32'h00000010, 1'b1);
    op_chk("pcrel_fwd", 2'd3, 26'h0000004, 32'h00000100, 32'h00000110, 1'b0);

    // start re-pulsed while busy: first request's result, one done only
    do_op(2'd1, 26'h0000055, 32'h0, 1'b1, t, w, l);
    chk("poke_lat", l, 3);
    chk("poke_tgt", t, 32'h00000055);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("poke_ndone", ndone, 0);

    // start held: done every 4 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd1; bus.imm = 26'h0000ABC; bus.pc = '0;
    ndone = 0; first = -1; last = -1; gap = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (last >= 0) gap = c - last;
        if (first < 0) first = c;
        last = c;
        ndone++;
      end
    end
    bus.start = 1'b0;
    chk("held_gap", gap, 4);
    chk("held_ndone", ndone, 3);
    chk("held_first", first, 2);
    repeat (4) @(negedge clk);

    // reset during COMBINE aborts the request
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd3; bus.imm = 26'h0000008; bus.pc = 32'hFFFFFFF0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
    chk("mid_rst_tgt", bus.target, 32'd0);
    chk("mid_rst_wrap", {31'b0, bus.wrap}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    op_chk("post_rst", 2'd3, 26'h0000008, 32'hFFFFFFF0, 32'h00000010, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
